uart_tx: RTL

Synthesizable, parametrised UART transmitter: the RTL successor to the bench-only serial line driver used by the simulation environment. It accepts parallel words over a valid/ready handshake and buffers them in a small internal FIFO. Each word is serialised LSB-first on a single idle-high line, with configurable data width, parity mode, stop-bit count and bit period. It sits between the host-side command logic and the board's serial TX pin, and also drives the receive path in loopback benches.

---
 rtl/uart_tx.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered, parametrised UART transmitter (LSB first, idle-high line)
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = 4;
    localparam logic [TW-1:0] TICK_AT   = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 fifo_full, fifo_empty;
    logic                 push, pop;
    logic [DATA_BITS-1:0] head;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 tick;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = tx_valid && !fifo_full;
    assign head       = mem_q[rd_ptr_q];
    assign tick       = (timer_q == TICK_AT);

    // Storage has no reset: emptiness is carried entirely by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q   <= count_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
        end
    end

    // Timer restarts at every symbol boundary, so symbol lengths never drift.
    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        pop       = 1'b0;
        if (state_q != S_IDLE) begin
            timer_d = tick ? '0 : timer_q + TW'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = head;
                    par_d     = (PARITY == 2) ? ^head : ~^head;
                    bit_cnt_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (bit_cnt_q != LAST_STOP) begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end else if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = head;
                        par_d     = (PARITY == 2) ? ^head : ~^head;
                        bit_cnt_d = '0;
                        state_d   = S_START;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line level is decoded from the next state so tx changes on the same edge as the FSM.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = !fifo_full;
    assign busy     = (state_q != S_IDLE) || !fifo_empty;

endmodule
